// File: rtl/uart_echofifo_pkg.sv
// Shared definitions for the UART echo FIFO: byte width and the transmit-side
// handshake state encoding.
package uart_echofifo_pkg;

  localparam int BYTE_W = 8;

  // Transmit handshake states.
  // ST_ARM is a guard cycle that gives txbusy time to rise after load.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ARM  = 2'd2,
    ST_BUSY = 2'd3
  } echo_state_e;

endpackage

// File: rtl/uart_echofifo_m_fifo.sv
// Synchronous byte FIFO with wrap-bit pointers, a registered occupancy count,
// a sticky overflow flag and a registered read port. The read port only
// updates on an accepted pop, so its value is held between pops.
module fifo_sync_m
  import uart_echofifo_pkg::*;
#(
  parameter int DEPTHLOG2 = 4,
  parameter int DATA_W    = BYTE_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic                 rd_en,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 empty,
  output logic [DEPTHLOG2:0]   level,
  output logic                 overflow,
  input  logic                 ovfclr
);

  localparam int DEPTH = 1 << DEPTHLOG2;
  localparam int PW    = DEPTHLOG2 + 1;

  logic [DATA_W-1:0]    mem [DEPTH];
  logic [PW-1:0]        wptr;
  logic [PW-1:0]        rptr;
  logic [PW-1:0]        wptr_nxt;
  logic [PW-1:0]        rptr_nxt;
  logic [DEPTHLOG2-1:0] widx;
  logic [DEPTHLOG2-1:0] ridx;
  logic                 full;
  logic                 pop_ok;
  logic                 push_ok;
  logic                 drop;

  assign widx  = wptr[DEPTHLOG2-1:0];
  assign ridx  = rptr[DEPTHLOG2-1:0];
  assign empty = (wptr == rptr);
  assign full  = (wptr[DEPTHLOG2] != rptr[DEPTHLOG2]) && (widx == ridx);

  // A pop in the same cycle frees a slot, so a push into a full FIFO is
  // still accepted when it coincides with a pop.
  assign pop_ok   = rd_en && !empty;
  assign push_ok  = wr_en && (!full || pop_ok);
  assign drop     = wr_en && full && !pop_ok;
  assign wptr_nxt = wptr + PW'(push_ok);
  assign rptr_nxt = rptr + PW'(pop_ok);

  // Storage array: no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[widx] <= wr_data;
    end
  end

  // Registered read port, updated only when a byte is popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (pop_ok) begin
      rd_data <= mem[ridx];
    end
  end

  // Pointers and occupancy; level is registered from the next pointer values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      wptr  <= wptr_nxt;
      rptr  <= rptr_nxt;
      level <= wptr_nxt - rptr_nxt;
    end
  end

  // Sticky overflow: a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovfclr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_echofifo_m.sv
// Echo buffer between the UART receiver and transmitter: received bytes are
// queued and handed to the transmitter one at a time as txbusy allows.
module uart_echofifo_m
  import uart_echofifo_pkg::*;
#(
  parameter int DEPTHLOG2 = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bytercvd,
  input  logic [BYTE_W-1:0]    q,
  input  logic                 txbusy,
  output logic                 load,
  output logic [BYTE_W-1:0]    d,
  output logic [DEPTHLOG2:0]   level,
  output logic                 overflow,
  input  logic                 ovfclr
);

  echo_state_e state_q;
  echo_state_e state_nxt;
  logic        empty;
  logic        pop;

  // Popping happens on the IDLE->LOAD transition; the FIFO read register
  // then carries the byte as d, stable through LOAD and held afterwards.
  assign pop = (state_q == ST_IDLE) && !empty && !txbusy;

  fifo_sync_m #(
    .DEPTHLOG2 (DEPTHLOG2),
    .DATA_W    (BYTE_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (bytercvd),
    .wr_data  (q),
    .rd_en    (pop),
    .rd_data  (d),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .ovfclr   (ovfclr)
  );

  // Handshake next-state logic.
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      ST_IDLE: if (pop)     state_nxt = ST_LOAD;
      ST_LOAD:              state_nxt = ST_ARM;
      ST_ARM:               state_nxt = ST_BUSY;
      ST_BUSY: if (!txbusy) state_nxt = ST_IDLE;
      default:              state_nxt = ST_IDLE;
    endcase
  end

  // State register plus a registered load strobe that is high exactly in LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      load    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      load    <= (state_nxt == ST_LOAD);
    end
  end

endmodule

// File: tb/tb_uart_echofifo_m.sv
// Bench for uart_echofifo_m: a depth-16 instance with an automatic
// transmitter model and a depth-4 instance for the full/overflow cases.
module tb_uart_echofifo_m;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       byt_a, txbusy_a, load_a, ovf_a, ovfclr_a;
  logic [7:0] q_a, d_a;
  logic [4:0] level_a;
  logic       byt_b, txbusy_b, load_b, ovf_b, ovfclr_b;
  logic [7:0] q_b, d_b;
  logic [2:0] level_b;

  always #5 clk = ~clk;

  uart_echofifo_m #(.DEPTHLOG2(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bytercvd(byt_a), .q(q_a), .txbusy(txbusy_a),
    .load(load_a), .d(d_a), .level(level_a), .overflow(ovf_a), .ovfclr(ovfclr_a)
  );

  uart_echofifo_m #(.DEPTHLOG2(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bytercvd(byt_b), .q(q_b), .txbusy(txbusy_b),
    .load(load_b), .d(d_b), .level(level_b), .overflow(ovf_b), .ovfclr(ovfclr_b)
  );

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  logic [7:0] exp_qa[$];
  logic [7:0] exp_qb[$];
  int         n_in_a, n_out_a, n_in_b, n_out_b;
  int         last_a, last_b, busy_cnt, tx_len;
  bit         tx_auto, tx_rand;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance one clock; observe on the falling edge, score loads against the
  // queued bytes, check occupancy = accepted pushes - loads, run tx model A.
  task automatic tick();
    logic [7:0] e;
    int         len;
    @(negedge clk);
    cyc++;
    if (load_a === 1'b1) begin
      n_out_a++;
      chk("a_load_expected", 32'(exp_qa.size() > 0), 1);
      if (exp_qa.size() > 0) begin
        e = exp_qa.pop_front();
        chk("a_d_order", 32'(d_a), 32'(e));
      end
      chk("a_txbusy_low_at_load", 32'(txbusy_a), 0);
      if (last_a >= 0) chk("a_load_spacing", 32'(cyc - last_a >= 4), 1);
      last_a = cyc;
    end
    if (load_b === 1'b1) begin
      n_out_b++;
      chk("b_load_expected", 32'(exp_qb.size() > 0), 1);
      if (exp_qb.size() > 0) begin
        e = exp_qb.pop_front();
        chk("b_d_order", 32'(d_b), 32'(e));
      end
      chk("b_txbusy_low_at_load", 32'(txbusy_b), 0);
      if (last_b >= 0) chk("b_load_spacing", 32'(cyc - last_b >= 4), 1);
      last_b = cyc;
    end
    chk("a_level_model", 32'(level_a), 32'(n_in_a - n_out_a));
    chk("b_level_model", 32'(level_b), 32'(n_in_b - n_out_b));
    if (tx_auto) begin
      if (load_a === 1'b1) begin
        len      = tx_rand ? int'($urandom_range(0, 6)) : tx_len;
        busy_cnt = len;
        txbusy_a = (len > 0);
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) txbusy_a = 1'b0;
      end
    end
  endtask

  task automatic push_a(input logic [7:0] v);
    byt_a = 1'b1;
    q_a   = v;
    exp_qa.push_back(v);
    n_in_a++;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((exp_qa.size() != 0 || exp_qb.size() != 0) && k < budget) begin
      tick();
      k++;
    end
    chk("a_drain_done", 32'(exp_qa.size()), 0);
    chk("b_drain_done", 32'(exp_qb.size()), 0);
  endtask

  initial begin
    int sent;
    int guard;
    rst_n = 1'b0;
    byt_a = 1'b0; q_a = '0; txbusy_a = 1'b0; ovfclr_a = 1'b0;
    byt_b = 1'b0; q_b = '0; txbusy_b = 1'b0; ovfclr_b = 1'b0;
    n_in_a = 0; n_out_a = 0; n_in_b = 0; n_out_b = 0;
    last_a = -1; last_b = -1; busy_cnt = 0; tx_len = 0;
    tx_auto = 1'b0; tx_rand = 1'b0;

    // Power-on reset values
    repeat (2) tick();
    chk("rst_load_a", 32'(load_a), 0);
    chk("rst_d_a", 32'(d_a), 0);
    chk("rst_level_a", 32'(level_a), 0);
    chk("rst_ovf_a", 32'(ovf_a), 0);
    chk("rst_load_b", 32'(load_b), 0);
    chk("rst_d_b", 32'(d_b), 0);
    chk("rst_ovf_b", 32'(ovf_b), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Single byte: load exactly two cycles after the push
    tx_auto = 1'b1; tx_len = 3;
    push_a('hA5);
    tick();
    byt_a = 1'b0;
    chk("single_level_1", 32'(level_a), 1);
    chk("single_no_load_n1", 32'(load_a), 0);
    tick();
    chk("single_load_n2", 32'(load_a), 1);
    chk("single_d_n2", 32'(d_a), 'hA5);
    chk("single_level_0", 32'(level_a), 0);
    tick();
    chk("single_load_once", 32'(load_a), 0);
    chk("single_d_hold", 32'(d_a), 'hA5);
    repeat (8) tick();

    // Burst against a slow transmitter
    tx_len = 100;
    for (int i = 1; i <= 5; i++) begin
      push_a(8'(i));
      tick();
    end
    byt_a = 1'b0;
    drain(2000);
    chk("burst_load_count", 32'(n_out_a), 6);
    repeat (110) tick();

    // Overflow on the depth-4 instance
    txbusy_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      byt_b = 1'b1;
      q_b   = 8'(8'h10 + i);
      if (i < 4) begin
        exp_qb.push_back(q_b);
        n_in_b++;
      end
      tick();
      if (i == 3) chk("b_ovf_not_yet", 32'(ovf_b), 0);
    end
    chk("b_level_full", 32'(level_b), 4);
    chk("b_ovf_set", 32'(ovf_b), 1);
    q_b = 8'h77; ovfclr_b = 1'b1;
    tick();
    chk("b_ovf_set_beats_clear", 32'(ovf_b), 1);
    byt_b = 1'b0;
    tick();
    ovfclr_b = 1'b0;
    chk("b_ovf_cleared", 32'(ovf_b), 0);
    txbusy_b = 1'b0;
    drain(200);
    chk("b_drain_loads", 32'(n_out_b), 4);
    chk("b_ovf_stays_clear", 32'(ovf_b), 0);
    repeat (6) tick();

    // Reset in the middle of a transmit with bytes queued
    tx_len = 50;
    for (int i = 0; i < 4; i++) begin
      push_a(8'(8'hC0 + i));
      tick();
    end
    byt_a = 1'b0;
    txbusy_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      byt_b = 1'b1;
      q_b   = 8'(8'h30 + i);
      if (i < 4) begin
        exp_qb.push_back(q_b);
        n_in_b++;
      end
      tick();
    end
    byt_b = 1'b0;
    chk("midbusy_level_a", 32'(level_a), 3);
    chk("midbusy_txbusy_a", 32'(txbusy_a), 1);
    chk("midbusy_ovf_b", 32'(ovf_b), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_load_a", 32'(load_a), 0);
    chk("arst_level_a", 32'(level_a), 0);
    chk("arst_d_a", 32'(d_a), 0);
    chk("arst_level_b", 32'(level_b), 0);
    chk("arst_ovf_b", 32'(ovf_b), 0);
    exp_qa.delete(); exp_qb.delete();
    n_in_a = 0; n_out_a = 0; n_in_b = 0; n_out_b = 0;
    last_a = -1; last_b = -1; busy_cnt = 0;
    txbusy_a = 1'b0; txbusy_b = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (12) tick();
    chk("no_load_after_reset_a", 32'(n_out_a), 0);
    chk("no_load_after_reset_b", 32'(n_out_b), 0);

    // Wrap-around stream with random transmit durations
    tx_rand = 1'b1;
    sent = 0; guard = 0;
    while (sent < 40 && guard < 3000) begin
      if ((n_in_a - n_out_a) < 16 && $urandom_range(0, 1) == 1) begin
        push_a(8'($urandom));
        sent++;
      end else begin
        byt_a = 1'b0;
      end
      tick();
      guard++;
      chk("wrap_level_max", 32'(level_a <= 5'd16), 1);
    end
    byt_a = 1'b0;
    chk("wrap_sent", 32'(sent), 40);
    drain(3000);
    chk("wrap_load_count", 32'(n_out_a), 40);
    repeat (12) tick();

    // Full FIFO with a push on the IDLE->LOAD cycle
    tx_auto = 1'b0; tx_rand = 1'b0; busy_cnt = 0;
    txbusy_a = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push_a(8'(8'h80 + i));
      tick();
    end
    byt_a = 1'b0;
    chk("full_level_16", 32'(level_a), 16);
    chk("full_ovf_clear", 32'(ovf_a), 0);
    tx_auto = 1'b1; tx_len = 2;
    txbusy_a = 1'b0;
    push_a('hEE);
    tick();
    byt_a = 1'b0;
    chk("fullpp_load", 32'(load_a), 1);
    chk("fullpp_level_16", 32'(level_a), 16);
    chk("fullpp_ovf_clear", 32'(ovf_a), 0);
    drain(500);
    chk("fullpp_ovf_after_drain", 32'(ovf_a), 0);
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
